// File: rtl/phy_rx_pkt_fifo_pkg.sv
// Shared types and constants for the PHY receive store-and-forward frame buffer.
// A stored beat is {last, keep[3:0], data[31:0]}.
package phy_rx_pkt_fifo_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned KEEP_W         = 4;
    localparam int unsigned BEAT_W         = 1 + KEEP_W + DATA_W;
    localparam int unsigned DEFAULT_ADDR_W = 9;

    // Only the last beat of a frame may carry a partial keep.
    typedef enum logic [KEEP_W-1:0] {
        KeepB1 = 4'b1000,
        KeepB2 = 4'b1100,
        KeepB3 = 4'b1110,
        KeepB4 = 4'b1111
    } keep_e;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [0:0] {
        StAccept,
        StDrop
    } wr_state_e;

endpackage

// File: rtl/phy_rx_pkt_fifo_if.sv
// AXI-Stream beat bundle. The receive side carries ready for symmetry; the buffer ties it high.
interface phy_rx_pkt_fifo_if;
    import phy_rx_pkt_fifo_pkg::*;

    logic              valid;
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output last, output keep, output data, input ready);
    modport slave  (input valid, input last, input keep, input data, output ready);

endinterface

// File: rtl/phy_rx_pkt_fifo_sdpram.sv
// Simple dual-port RAM with one registered read port; no reset so it maps onto block RAM.
module phy_rx_pkt_fifo_sdpram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WIDTH  = 37
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/phy_rx_pkt_fifo.sv
// Store-and-forward frame buffer: frames are committed on their last beat, overflowing frames are
// dropped atomically, and committed frames are replayed through a 2-entry skid buffer.
module phy_rx_pkt_fifo
    import phy_rx_pkt_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    phy_rx_pkt_fifo_if.slave        i_axi_s,
    phy_rx_pkt_fifo_if.master       o_axi_m,
    output logic                    o_drop,
    output logic [ADDR_W:0]         o_frame_cnt
);

    localparam logic [ADDR_W:0] PtrOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};

    wr_state_e       state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] wr_commit_q, wr_commit_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] frame_cnt_q, frame_cnt_d;
    logic            drop_q, drop_d;
    logic            inflight_q;
    logic [1:0]      skid_cnt_q, skid_cnt_d, skid_base;
    beat_t           head_q, head_d, tail_q, tail_d;
    beat_t           wr_beat, ram_rdata;
    logic            full, wr_en, commit, fetch, pop, retire;

    assign i_axi_s.ready = 1'b1;
    assign wr_beat       = {i_axi_s.last, i_axi_s.keep, i_axi_s.data};
    assign full          = (wr_ptr_q - rd_ptr_q) == FullCnt;
    assign commit        = wr_en & i_axi_s.last;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_d      = 1'b0;
        wr_en       = 1'b0;
        unique case (state_q)
            StAccept: begin
                if (i_axi_s.valid) begin
                    if (!full) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                        if (i_axi_s.last) begin
                            wr_commit_d = wr_ptr_q + PtrOne;
                        end
                    end else begin
                        // Rewind discards the partial frame in one step.
                        wr_ptr_d = wr_commit_q;
                        if (i_axi_s.last) begin
                            drop_d = 1'b1;
                        end else begin
                            state_d = StDrop;
                        end
                    end
                end
            end
            StDrop: begin
                if (i_axi_s.valid && i_axi_s.last) begin
                    drop_d  = 1'b1;
                    state_d = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase
    end

    phy_rx_pkt_fifo_sdpram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (BEAT_W)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_beat),
        .re_i    (fetch),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign pop    = o_axi_m.valid & o_axi_m.ready;
    assign retire = pop & head_q.last;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        skid_base = skid_cnt_q;
        if (pop) begin
            head_d    = tail_q;
            skid_base = skid_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (skid_base == 2'd0) begin
                head_d = ram_rdata;
            end else begin
                tail_d = ram_rdata;
            end
        end
        skid_cnt_d = skid_base + {1'b0, inflight_q};
        // Counting the current pop keeps the stream bubble-free while never overfilling two slots.
        fetch    = (rd_ptr_q != wr_commit_q) &&
                   (({1'b0, skid_base} + {2'b00, inflight_q}) < 3'd2);
        rd_ptr_d = fetch ? rd_ptr_q + PtrOne : rd_ptr_q;
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (commit && !retire) begin
            frame_cnt_d = frame_cnt_q + PtrOne;
        end else if (retire && !commit) begin
            frame_cnt_d = frame_cnt_q - PtrOne;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StAccept;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            drop_q      <= 1'b0;
            inflight_q  <= 1'b0;
            skid_cnt_q  <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
            inflight_q  <= fetch;
            skid_cnt_q  <= skid_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    assign o_axi_m.valid = skid_cnt_q != 2'd0;
    assign o_axi_m.last  = head_q.last;
    assign o_axi_m.keep  = head_q.keep;
    assign o_axi_m.data  = head_q.data;
    assign o_drop        = drop_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_phy_rx_pkt_fifo.sv
// Scoreboard bench for phy_rx_pkt_fifo: a deep (ADDR_W=9) and a shallow (ADDR_W=4) instance.
module tb_phy_rx_pkt_fifo;
    import phy_rx_pkt_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst9, rst4;
    logic       drop9, drop4;
    logic [9:0] cnt9;
    logic [4:0] cnt4;
    logic       rnd_ready  = 1'b0;
    logic       ready9_cmd = 1'b0;

    int    checks = 0;
    int    errors = 0;
    int    drops9 = 0;
    int    drops4 = 0;
    beat_t exp9[$];
    beat_t exp4[$];
    beat_t frame_q[$];

    phy_rx_pkt_fifo_if s9 ();
    phy_rx_pkt_fifo_if m9 ();
    phy_rx_pkt_fifo_if s4 ();
    phy_rx_pkt_fifo_if m4 ();

    phy_rx_pkt_fifo #(.ADDR_W(9)) u_dut9 (
        .i_clk       (clk),
        .i_rst       (rst9),
        .i_axi_s     (s9),
        .o_axi_m     (m9),
        .o_drop      (drop9),
        .o_frame_cnt (cnt9)
    );

    phy_rx_pkt_fifo #(.ADDR_W(4)) u_dut4 (
        .i_clk       (clk),
        .i_rst       (rst4),
        .i_axi_s     (s4),
        .o_axi_m     (m4),
        .o_drop      (drop4),
        .o_frame_cnt (cnt4)
    );

    beat_t m9_beat, m4_beat;
    assign m9_beat = {m9.last, m9.keep, m9.data};
    assign m4_beat = {m4.last, m4.keep, m4.data};

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [3:0] rand_keep();
        case (2'($urandom_range(0, 3)))
            2'd0:    return KeepB1;
            2'd1:    return KeepB2;
            2'd2:    return KeepB3;
            default: return KeepB4;
        endcase
    endfunction

    function automatic void gen_frame(input int len);
        beat_t b;
        frame_q.delete();
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.last = (i == len - 1);
            b.keep = b.last ? rand_keep() : 4'hF;
            frame_q.push_back(b);
        end
    endfunction

    // Random ready for the deep instance, applied mid-cycle so it never races the edge.
    initial forever begin
        @(posedge clk);
        #2;
        m9.ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready9_cmd;
    end

    // Monitors: pop and compare on every handshake, and require a stalled beat to hold.
    initial begin : mon9
        logic  stall = 1'b0;
        beat_t held;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst9) begin
                stall = 1'b0;
            end else begin
                if (drop9) drops9++;
                if (stall) begin
                    check("hold9_valid", 64'(m9.valid), 64'd1);
                    check("hold9_beat", 64'(m9_beat), 64'(held));
                end
                if (m9.valid && m9.ready) begin
                    if (exp9.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexp9 actual %0h required no beat", m9_beat);
                    end else begin
                        e = exp9.pop_front();
                        check("beat9", 64'(m9_beat), 64'(e));
                    end
                end
                stall = m9.valid && !m9.ready;
                held  = m9_beat;
            end
        end
    end

    initial begin : mon4
        logic  stall = 1'b0;
        beat_t held;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst4) begin
                stall = 1'b0;
            end else begin
                if (drop4) drops4++;
                if (stall) begin
                    check("hold4_valid", 64'(m4.valid), 64'd1);
                    check("hold4_beat", 64'(m4_beat), 64'(held));
                end
                if (m4.valid && m4.ready) begin
                    if (exp4.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexp4 actual %0h required no beat", m4_beat);
                    end else begin
                        e = exp4.pop_front();
                        check("beat4", 64'(m4_beat), 64'(e));
                    end
                end
                stall = m4.valid && !m4.ready;
                held  = m4_beat;
            end
        end
    end

    task automatic idle9();
        s9.valid = 1'b0;
        s9.last  = 1'($urandom);
        s9.keep  = 4'($urandom);
        s9.data  = $urandom;
    endtask

    task automatic idle4();
        s4.valid = 1'b0;
        s4.last  = 1'($urandom);
        s4.keep  = 4'($urandom);
        s4.data  = $urandom;
    endtask

    task automatic send9(input bit expect_out);
        if (expect_out) foreach (frame_q[i]) exp9.push_back(frame_q[i]);
        foreach (frame_q[i]) begin
            s9.valid = 1'b1;
            {s9.last, s9.keep, s9.data} = frame_q[i];
            @(posedge clk);
            #1;
        end
        idle9();
    endtask

    task automatic send4(input bit expect_out);
        if (expect_out) foreach (frame_q[i]) exp4.push_back(frame_q[i]);
        foreach (frame_q[i]) begin
            s4.valid = 1'b1;
            {s4.last, s4.keep, s4.data} = frame_q[i];
            @(posedge clk);
            #1;
        end
        idle4();
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain9(input string name);
        int n = 0;
        while ((exp9.size() != 0 || m9.valid) && n < 20000) begin
            cycles(1);
            n++;
        end
        if (n >= 20000) timeout(name);
    endtask

    task automatic drain4(input string name);
        int n = 0;
        while ((exp4.size() != 0 || m4.valid) && n < 2000) begin
            cycles(1);
            n++;
        end
        if (n >= 2000) timeout(name);
    endtask

    initial begin
        beat_t b;
        int    n;
        int    len;

        rst9     = 1'b1;
        rst4     = 1'b1;
        m4.ready = 1'b0;
        idle9();
        idle4();
        cycles(3);
        check("rst9_valid", 64'(m9.valid), 64'd0);
        check("rst9_beat", 64'(m9_beat), 64'd0);
        check("rst9_cnt", 64'(cnt9), 64'd0);
        check("rst9_drop", 64'(drop9), 64'd0);
        check("rst9_sready", 64'(s9.ready), 64'd1);
        check("rst4_valid", 64'(m4.valid), 64'd0);
        check("rst4_beat", 64'(m4_beat), 64'd0);
        check("rst4_cnt", 64'(cnt4), 64'd0);
        check("rst4_drop", 64'(drop4), 64'd0);
        rst9 = 1'b0;
        rst4 = 1'b0;

        // Single 3-beat frame with ready high: first beat two edges after the last input beat.
        ready9_cmd = 1'b1;
        cycles(2);
        frame_q.delete();
        b = {1'b0, 4'b1111, 32'h1111_1111}; frame_q.push_back(b);
        b = {1'b0, 4'b1111, 32'h2222_2222}; frame_q.push_back(b);
        b = {1'b1, 4'b1100, 32'h3333_0000}; frame_q.push_back(b);
        send9(1'b1);
        check("t1_valid_t0", 64'(m9.valid), 64'd0);
        check("t1_cnt_commit", 64'(cnt9), 64'd1);
        cycles(1);
        check("t1_valid_t1", 64'(m9.valid), 64'd0);
        cycles(1);
        check("t1_valid_t2", 64'(m9.valid), 64'd1);
        check("t1_first_beat", 64'(m9_beat), 64'h0f_1111_1111);
        drain9("t1_drain");
        check("t1_cnt_done", 64'(cnt9), 64'd0);

        // Two frames arrive while stalled, then released.
        ready9_cmd = 1'b0;
        cycles(2);
        gen_frame(4);
        send9(1'b1);
        gen_frame(2);
        send9(1'b1);
        cycles(4);
        check("t2_cnt", 64'(cnt9), 64'd2);
        check("t2_valid", 64'(m9.valid), 64'd1);
        check("t2_head", 64'(m9_beat), 64'(exp9[0]));
        ready9_cmd = 1'b1;
        drain9("t2_drain");
        check("t2_cnt_done", 64'(cnt9), 64'd0);

        // 200 random frames with 50% ready, paced so the buffer cannot overflow.
        rnd_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 40);
            gen_frame(len);
            n = 0;
            while (exp9.size() + len > 400 && n < 2000) begin
                cycles(1);
                n++;
            end
            if (n >= 2000) timeout("t3_pace");
            repeat ($urandom_range(0, 3)) begin
                idle9();
                cycles(1);
            end
            send9(1'b1);
        end
        drain9("t3_drain");
        rnd_ready  = 1'b0;
        ready9_cmd = 1'b1;
        check("t3_drops", 64'(drops9), 64'd0);
        check("t3_cnt_done", 64'(cnt9), 64'd0);

        // Shallow buffer: oversize frame dropped, then an exactly-full frame accepted.
        gen_frame(20);
        send4(1'b0);
        cycles(5);
        check("t4_drops", 64'(drops4), 64'd1);
        check("t4_valid", 64'(m4.valid), 64'd0);
        check("t4_cnt", 64'(cnt4), 64'd0);
        gen_frame(16);
        send4(1'b1);
        cycles(4);
        check("t4_cnt_full", 64'(cnt4), 64'd1);
        m4.ready = 1'b1;
        drain4("t4_drain");
        check("t4_drops_after", 64'(drops4), 64'd1);
        check("t4_cnt_done", 64'(cnt4), 64'd0);

        // Frame A stalled in the buffer, frame B cannot fit, frame C fits after A drains.
        m4.ready = 1'b0;
        gen_frame(10);
        send4(1'b1);
        cycles(5);
        gen_frame(9);
        send4(1'b0);
        cycles(5);
        check("t5_drops", 64'(drops4), 64'd2);
        check("t5_cnt", 64'(cnt4), 64'd1);
        m4.ready = 1'b1;
        drain4("t5_drain_a");
        gen_frame(6);
        send4(1'b1);
        drain4("t5_drain_c");
        check("t5_drops_after", 64'(drops4), 64'd2);
        check("t5_cnt_done", 64'(cnt4), 64'd0);

        // Reset in the middle of a 5-beat readout.
        ready9_cmd = 1'b0;
        cycles(2);
        gen_frame(5);
        send9(1'b1);
        n = 0;
        while (!m9.valid && n < 50) begin
            cycles(1);
            n++;
        end
        if (n >= 50) timeout("t6_wait_valid");
        ready9_cmd = 1'b1;
        cycles(2);
        check("t6_left_before_rst", 64'(exp9.size()), 64'd3);
        ready9_cmd = 1'b0;
        rst9       = 1'b1;
        cycles(1);
        rst9 = 1'b0;
        exp9.delete();
        check("t6_valid", 64'(m9.valid), 64'd0);
        check("t6_beat", 64'(m9_beat), 64'd0);
        check("t6_cnt", 64'(cnt9), 64'd0);
        check("t6_drop", 64'(drop9), 64'd0);
        cycles(4);
        check("t6_valid_idle", 64'(m9.valid), 64'd0);
        gen_frame(3);
        send9(1'b1);
        ready9_cmd = 1'b1;
        drain9("t6_drain");
        check("t6_cnt_done", 64'(cnt9), 64'd0);
        check("t6_drops", 64'(drops9), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
